pool_stream_engine: RTL and testbench

- Sequential pooling engine placed after the activation-function stage and ahead of the output SRAM packer.
- Walks a runtime-sized activation tile held in a read-only activation buffer and computes NONE, MAX or AVG pooling for each output position, with runtime kernel size and stride.
- Emits one saturated BIN_LEN result per output position over a valid/ready stream, in row-major order.
- Replaces the combinational full-array pooling with an iterative datapath: one activation read per cycle, one accumulator.

---
 rtl/pool_stream_engine_if.sv | 36 +++
 rtl/pool_stream_engine.sv | 233 +++++++++++++++++++++++
 tb/tb_pool_stream_engine.sv | 476 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pool_stream_engine_if.sv
// Activation-buffer read port plus pooled-result valid/ready stream.
// The engine uses the master modport; the buffer/packer side uses slave.
interface pool_stream_engine_if #(
    parameter int unsigned OUT_BIN_LEN = 32,
    parameter int unsigned BIN_LEN     = 16,
    parameter int unsigned MAX_H       = 16,
    parameter int unsigned MAX_W       = 16
);
    localparam int unsigned RowW = $clog2(MAX_H);
    localparam int unsigned ColW = $clog2(MAX_W);

    logic                   act_rd_en;
    logic [RowW-1:0]        act_rd_row;
    logic [ColW-1:0]        act_rd_col;
    logic [OUT_BIN_LEN-1:0] act_rd_data;

    logic                   out_valid;
    logic                   out_ready;
    logic [RowW-1:0]        out_row;
    logic [ColW-1:0]        out_col;
    logic [BIN_LEN-1:0]     out_data;

    modport master (
        output act_rd_en, act_rd_row, act_rd_col,
        input  act_rd_data,
        output out_valid, out_row, out_col, out_data,
        input  out_ready
    );

    modport slave (
        input  act_rd_en, act_rd_row, act_rd_col,
        output act_rd_data,
        input  out_valid, out_row, out_col, out_data,
        output out_ready
    );
endinterface

// File: rtl/pool_stream_engine.sv
// Iterative NONE/MAX/AVG pooling over an activation tile: one buffer read per cycle,
// one accumulator, one saturated result per output position on a valid/ready stream.
module pool_stream_engine #(
    parameter int unsigned OUT_BIN_LEN = 32,
    parameter int unsigned BIN_LEN     = 16,
    parameter int unsigned MAX_H       = 16,
    parameter int unsigned MAX_W       = 16,
    parameter int unsigned MAX_K       = 4,
    localparam int unsigned HW   = $clog2(MAX_H + 1),
    localparam int unsigned WW   = $clog2(MAX_W + 1),
    localparam int unsigned RowW = $clog2(MAX_H),
    localparam int unsigned ColW = $clog2(MAX_W)
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      start_i,
    input  logic [1:0]                pool_type_i,
    input  logic [2:0]                pool_stride_i,
    input  logic [2:0]                pool_kernel_size_i,
    input  logic [HW-1:0]             in_height_i,
    input  logic [WW-1:0]             in_width_i,
    pool_stream_engine_if.master      bus,
    output logic                      busy_o,
    output logic                      done_o,
    output logic                      cfg_err_o
);
    localparam int unsigned AccW = OUT_BIN_LEN + 4;
    localparam int unsigned GW   = ((HW > WW) ? HW : WW) + 2;

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StFetch = 3'd1;
    localparam logic [2:0] StWait  = 3'd2;
    localparam logic [2:0] StEmit  = 3'd3;
    localparam logic [2:0] StDone  = 3'd4;

    localparam logic [1:0] PoolNone = 2'd0;
    localparam logic [1:0] PoolMax  = 2'd1;
    localparam logic [1:0] PoolAvg  = 2'd2;
    localparam logic [1:0] PoolRsvd = 2'd3;

    localparam logic signed [AccW-1:0] SatMax = {{(AccW-BIN_LEN+1){1'b0}}, {(BIN_LEN-1){1'b1}}};
    localparam logic signed [AccW-1:0] SatMin = {{(AccW-BIN_LEN+1){1'b1}}, {(BIN_LEN-1){1'b0}}};

    logic [2:0]             state_q, state_d;
    logic [1:0]             type_q, type_d;
    logic [2:0]             k_q, k_d, s_q, s_d;
    logic [2:0]             kr_q, kr_d, kc_q, kc_d;
    logic [HW-1:0]          h_q, h_d;
    logic [WW-1:0]          w_q, w_d;
    logic [RowW-1:0]        r_q, r_d, rb_q, rb_d;
    logic [ColW-1:0]        c_q, c_d, cb_q, cb_d;
    logic signed [AccW-1:0] acc_q, acc_d;
    logic                   rd_valid_q, rd_first_q;
    logic                   cfg_err_q, cfg_err_d;

    logic                   rd_en, emit;
    logic [2:0]             k_eff, s_eff;
    logic                   cfg_bad;
    logic                   col_fits, row_fits;
    logic signed [AccW-1:0] data_ext, shifted;
    logic [2:0]             avg_shift;
    logic [BIN_LEN-1:0]     result;

    assign rd_en    = (state_q == StFetch);
    assign emit     = (state_q == StEmit);
    assign data_ext = AccW'($signed(bus.act_rd_data));

    // NONE pooling is a 1x1 window with unit stride regardless of the kernel/stride inputs.
    always_comb begin
        k_eff   = (pool_type_i == PoolNone) ? 3'd1 : pool_kernel_size_i;
        s_eff   = (pool_type_i == PoolNone) ? 3'd1 : pool_stride_i;
        cfg_bad = (pool_type_i == PoolRsvd) || (k_eff == 3'd0) || (s_eff == 3'd0) ||
                  (32'(k_eff) > MAX_K) || (32'(k_eff) > 32'(in_height_i)) ||
                  (32'(k_eff) > 32'(in_width_i)) ||
                  ((pool_type_i == PoolAvg) &&
                   !((k_eff == 3'd1) || (k_eff == 3'd2) || (k_eff == 3'd4)));
    end

    // Advance to the next window only while it still lies fully inside the tile.
    assign col_fits = (GW'(cb_q) + GW'(s_q) + GW'(k_q)) <= GW'(w_q);
    assign row_fits = (GW'(rb_q) + GW'(s_q) + GW'(k_q)) <= GW'(h_q);

    always_comb begin
        state_d   = state_q;
        type_d    = type_q;
        k_d       = k_q;
        s_d       = s_q;
        h_d       = h_q;
        w_d       = w_q;
        kr_d      = kr_q;
        kc_d      = kc_q;
        r_d       = r_q;
        c_d       = c_q;
        rb_d      = rb_q;
        cb_d      = cb_q;
        cfg_err_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    if (cfg_bad) begin
                        cfg_err_d = 1'b1;
                    end else begin
                        type_d  = pool_type_i;
                        k_d     = k_eff;
                        s_d     = s_eff;
                        h_d     = in_height_i;
                        w_d     = in_width_i;
                        kr_d    = '0;
                        kc_d    = '0;
                        r_d     = '0;
                        c_d     = '0;
                        rb_d    = '0;
                        cb_d    = '0;
                        state_d = StFetch;
                    end
                end
            end
            StFetch: begin
                if (kc_q == k_q - 3'd1) begin
                    kc_d = '0;
                    if (kr_q == k_q - 3'd1) begin
                        kr_d    = '0;
                        state_d = StWait;
                    end else begin
                        kr_d = kr_q + 3'd1;
                    end
                end else begin
                    kc_d = kc_q + 3'd1;
                end
            end
            StWait: state_d = StEmit;
            StEmit: begin
                if (bus.out_ready) begin
                    if (col_fits) begin
                        c_d     = c_q + ColW'(1);
                        cb_d    = cb_q + ColW'(s_q);
                        state_d = StFetch;
                    end else if (row_fits) begin
                        c_d     = '0;
                        cb_d    = '0;
                        r_d     = r_q + RowW'(1);
                        rb_d    = rb_q + RowW'(s_q);
                        state_d = StFetch;
                    end else begin
                        state_d = StDone;
                    end
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Read data lands one cycle after the strobe; the window's first element seeds acc.
    always_comb begin
        acc_d = acc_q;
        if (rd_valid_q) begin
            if (rd_first_q) begin
                acc_d = data_ext;
            end else if (type_q == PoolMax) begin
                acc_d = (data_ext > acc_q) ? data_ext : acc_q;
            end else begin
                acc_d = acc_q + data_ext;
            end
        end
    end

    always_comb begin
        case (k_q)
            3'd2:    avg_shift = 3'd2;
            3'd4:    avg_shift = 3'd4;
            default: avg_shift = 3'd0;
        endcase
        shifted = (type_q == PoolAvg) ? (acc_q >>> avg_shift) : acc_q;
        if (shifted > SatMax) begin
            result = SatMax[BIN_LEN-1:0];
        end else if (shifted < SatMin) begin
            result = SatMin[BIN_LEN-1:0];
        end else begin
            result = shifted[BIN_LEN-1:0];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            type_q     <= '0;
            k_q        <= '0;
            s_q        <= '0;
            h_q        <= '0;
            w_q        <= '0;
            kr_q       <= '0;
            kc_q       <= '0;
            r_q        <= '0;
            c_q        <= '0;
            rb_q       <= '0;
            cb_q       <= '0;
            acc_q      <= '0;
            rd_valid_q <= 1'b0;
            rd_first_q <= 1'b0;
            cfg_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            type_q     <= type_d;
            k_q        <= k_d;
            s_q        <= s_d;
            h_q        <= h_d;
            w_q        <= w_d;
            kr_q       <= kr_d;
            kc_q       <= kc_d;
            r_q        <= r_d;
            c_q        <= c_d;
            rb_q       <= rb_d;
            cb_q       <= cb_d;
            acc_q      <= acc_d;
            rd_valid_q <= rd_en;
            rd_first_q <= rd_en && (kr_q == 3'd0) && (kc_q == 3'd0);
            cfg_err_q  <= cfg_err_d;
        end
    end

    assign bus.act_rd_en  = rd_en;
    assign bus.act_rd_row = rd_en ? (rb_q + RowW'(kr_q)) : '0;
    assign bus.act_rd_col = rd_en ? (cb_q + ColW'(kc_q)) : '0;
    assign bus.out_valid  = emit;
    assign bus.out_row    = r_q;
    assign bus.out_col    = c_q;
    assign bus.out_data   = emit ? result : '0;

    assign busy_o    = (state_q == StFetch) || (state_q == StWait) || emit;
    assign done_o    = (state_q == StDone);
    assign cfg_err_o = cfg_err_q;
endmodule

// File: tb/tb_pool_stream_engine.sv
// Scoreboard bench for pool_stream_engine: expected words are queued as each pass is
// launched and popped by a monitor on every output handshake.
module tb_pool_stream_engine;
    localparam int unsigned OBL = 32;
    localparam int unsigned BL  = 16;
    localparam int unsigned MH  = 16;
    localparam int unsigned MW  = 16;
    localparam int unsigned MK  = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       start = 1'b0;
    logic [1:0] ptype = '0;
    logic [2:0] pstride = '0;
    logic [2:0] pksize = '0;
    logic [4:0] ih = '0;
    logic [4:0] iw = '0;
    logic       busy, done, cfg_err;

    always #5 clk = ~clk;

    pool_stream_engine_if #(.OUT_BIN_LEN(OBL), .BIN_LEN(BL), .MAX_H(MH), .MAX_W(MW)) bus ();

    pool_stream_engine #(
        .OUT_BIN_LEN(OBL), .BIN_LEN(BL), .MAX_H(MH), .MAX_W(MW), .MAX_K(MK)
    ) dut (
        .clk_i              (clk),
        .rst_ni             (rst_n),
        .start_i            (start),
        .pool_type_i        (ptype),
        .pool_stride_i      (pstride),
        .pool_kernel_size_i (pksize),
        .in_height_i        (ih),
        .in_width_i         (iw),
        .bus                (bus),
        .busy_o             (busy),
        .done_o             (done),
        .cfg_err_o          (cfg_err)
    );

    typedef struct {
        int row;
        int col;
        int data;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   mem [16][16];
    int   total = 0;
    int   bad = 0;
    int   hs_count = 0;
    int   rd_count = 0;
    int   rd_row_log[$];
    int   rd_col_log[$];

    initial bus.out_ready = 1'b1;

    // Activation buffer: one-cycle read latency, junk when not strobed.
    always @(posedge clk) begin
        bus.act_rd_data <= bus.act_rd_en ? mem[bus.act_rd_row][bus.act_rd_col] : 32'h5A5A_A5A5;
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.act_rd_en) begin
                rd_count++;
                rd_row_log.push_back(int'(bus.act_rd_row));
                rd_col_log.push_back(int'(bus.act_rd_col));
            end
            if (bus.out_valid && bus.out_ready) begin
                hs_count++;
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_output got (%0d,%0d)=%0d required none",
                             bus.out_row, bus.out_col, $signed(bus.out_data));
                end else begin
                    mon_e = sb.pop_front();
                    if (int'(bus.out_row) !== mon_e.row || int'(bus.out_col) !== mon_e.col ||
                        int'($signed(bus.out_data)) !== mon_e.data) begin
                        bad++;
                        $display("FAIL output got (%0d,%0d)=%0d required (%0d,%0d)=%0d",
                                 bus.out_row, bus.out_col, $signed(bus.out_data),
                                 mon_e.row, mon_e.col, mon_e.data);
                    end
                end
            end
        end
    end

    task automatic push_exp(input int r, input int c, input int d);
        exp_t e;
        e.row = r;
        e.col = c;
        e.data = d;
        sb.push_back(e);
    endtask

    task automatic fill_seq(input int w);
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 16; c++) mem[r][c] = r * w + c;
    endtask

    task automatic fill_rand(input int span);
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 16; c++)
                mem[r][c] = (span == 0) ? int'($urandom()) :
                            int'($urandom_range(2 * span, 0)) - span;
    endtask

    task automatic model_push(input int t, input int s, input int k, input int h, input int w);
        int oh, ow, sh;
        longint acc, v;
        if (t == 0) begin
            k = 1;
            s = 1;
        end
        sh = (k == 4) ? 4 : (k == 2) ? 2 : 0;
        oh = (h - k) / s + 1;
        ow = (w - k) / s + 1;
        for (int r = 0; r < oh; r++) begin
            for (int c = 0; c < ow; c++) begin
                acc = 0;
                for (int kr = 0; kr < k; kr++) begin
                    for (int kc = 0; kc < k; kc++) begin
                        v = longint'(mem[r * s + kr][c * s + kc]);
                        if (kr == 0 && kc == 0) acc = v;
                        else if (t == 1) acc = (v > acc) ? v : acc;
                        else acc = acc + v;
                    end
                end
                if (t == 2) acc = acc >>> sh;
                if (acc > 32767) acc = 32767;
                else if (acc < -32768) acc = -32768;
                push_exp(r, c, int'(acc));
            end
        end
    endtask

    task automatic do_start(input int t, input int s, input int k, input int h, input int w);
        @(posedge clk);
        #1;
        ptype = 2'(t);
        pstride = 3'(s);
        pksize = 3'(k);
        ih = 5'(h);
        iw = 5'(w);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Launches a pass and counts cycles from the start cycle to done.
    task automatic run_pass(input int t, input int s, input int k, input int h, input int w,
                            input int stall, input int spur_at, input string name);
        int  n_out, kk, exp_cycles, n, first_v, errs;
        bit  got_done;
        kk = (t == 0) ? 1 : k * k;
        n_out = sb.size();
        exp_cycles = n_out * (kk + 2) + 1 + stall;
        do_start(t, s, k, h, w);
        n = 0;
        first_v = 0;
        errs = 0;
        got_done = 1'b0;
        while (!got_done && n < 3000) begin
            @(negedge clk);
            n++;
            start = 1'b0;
            if (n == spur_at) begin
                ptype = 2'd0;
                pstride = 3'd1;
                pksize = 3'd1;
                ih = 5'd2;
                iw = 5'd2;
                start = 1'b1;
            end
            if (bus.out_valid && first_v == 0) first_v = n;
            if (cfg_err) errs++;
            if (done) got_done = 1'b1;
        end
        start = 1'b0;
        total++;
        if (!got_done) begin
            bad++;
            $display("FAIL %s_timeout got no done after %0d cycles required done", name, n);
        end else if (n !== exp_cycles) begin
            bad++;
            $display("FAIL %s_cycles got %0d required %0d", name, n, exp_cycles);
        end
        total++;
        if (first_v !== kk + 2) begin
            bad++;
            $display("FAIL %s_first_valid got %0d required %0d", name, first_v, kk + 2);
        end
        total++;
        if (sb.size() !== 0) begin
            bad++;
            $display("FAIL %s_leftover got %0d pending required 0", name, sb.size());
        end
        sb.delete();
        total++;
        if (errs !== 0) begin
            bad++;
            $display("FAIL %s_cfg_err got %0d pulses required 0", name, errs);
        end
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL %s_idle got busy=%0b done=%0b required 0 0", name, busy, done);
        end
    endtask

    task automatic test_reset;
        #1 rst_n = 1'b0;
        #2;
        total++;
        if ({busy, done, cfg_err, bus.out_valid, bus.act_rd_en} !== 5'b0) begin
            bad++;
            $display("FAIL reset_ctrl got %b required 00000",
                     {busy, done, cfg_err, bus.out_valid, bus.act_rd_en});
        end
        total++;
        if ({bus.out_data, bus.out_row, bus.out_col} !== '0) begin
            bad++;
            $display("FAIL reset_data got %h required 0", {bus.out_data, bus.out_row, bus.out_col});
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        total++;
        if ({busy, done, bus.out_valid} !== 3'b0) begin
            bad++;
            $display("FAIL reset_release got %b required 000", {busy, done, bus.out_valid});
        end
    endtask

    task automatic test_none;
        fill_seq(2);
        mem[0][0] = 5;
        mem[0][1] = -3;
        mem[1][0] = 70000;
        mem[1][1] = -70000;
        push_exp(0, 0, 5);
        push_exp(0, 1, -3);
        push_exp(1, 0, 32767);
        push_exp(1, 1, -32768);
        run_pass(0, 1, 1, 2, 2, 0, 0, "none");
    endtask

    task automatic test_max;
        int exp_r[4] = '{0, 0, 1, 1};
        int exp_c[4] = '{0, 1, 0, 1};
        fill_seq(4);
        rd_row_log.delete();
        rd_col_log.delete();
        push_exp(0, 0, 5);
        push_exp(0, 1, 7);
        push_exp(1, 0, 13);
        push_exp(1, 1, 15);
        run_pass(1, 2, 2, 4, 4, 0, 0, "max");
        total++;
        if (rd_row_log.size() !== 16) begin
            bad++;
            $display("FAIL max_reads got %0d required 16", rd_row_log.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                total++;
                if (rd_row_log[i] !== exp_r[i] || rd_col_log[i] !== exp_c[i]) begin
                    bad++;
                    $display("FAIL max_addr%0d got (%0d,%0d) required (%0d,%0d)", i,
                             rd_row_log[i], rd_col_log[i], exp_r[i], exp_c[i]);
                end
            end
        end
    endtask

    task automatic test_avg;
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 16; c++) mem[r][c] = -3;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++) push_exp(r, c, -3);
        run_pass(2, 1, 2, 4, 4, 0, 0, "avg_neg");
        mem[0][0] = 1;
        mem[0][1] = 2;
        mem[1][0] = 2;
        mem[1][1] = 2;
        push_exp(0, 0, 1);
        run_pass(2, 1, 2, 2, 2, 0, 0, "avg_sum7");
    endtask

    task automatic test_random;
        fill_rand(0);
        model_push(1, 3, 3, 7, 8);
        run_pass(1, 3, 3, 7, 8, 0, 0, "max_rand");
        fill_rand(0);
        model_push(2, 2, 4, 6, 6);
        run_pass(2, 2, 4, 6, 6, 0, 0, "avg4_rand");
        fill_rand(0);
        model_push(0, 5, 3, 3, 5);
        run_pass(0, 5, 3, 3, 5, 0, 0, "none_rand");
        fill_rand(50);
        model_push(2, 2, 2, 5, 4);
        run_pass(2, 2, 2, 5, 4, 0, 0, "avg2_small");
        fill_rand(0);
        model_push(2, 2, 1, 5, 5);
        run_pass(2, 2, 1, 5, 5, 0, 0, "avg1_rand");
    endtask

    task automatic stall_proc;
        int hs0, r0, c0, d0, unstable, reads;
        bit hit;
        hs0 = hs_count;
        hit = 1'b0;
        unstable = 0;
        reads = 0;
        for (int i = 0; i < 200 && !hit; i++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid && hs_count == hs0 + 1) hit = 1'b1;
        end
        total++;
        if (!hit) begin
            bad++;
            $display("FAIL bp_second_valid got none required out_valid");
        end else begin
            bus.out_ready = 1'b0;
            r0 = int'(bus.out_row);
            c0 = int'(bus.out_col);
            d0 = int'(bus.out_data);
            for (int i = 0; i < 5; i++) begin
                @(negedge clk);
                if (!bus.out_valid || int'(bus.out_row) != r0 || int'(bus.out_col) != c0 ||
                    int'(bus.out_data) != d0) unstable++;
                if (bus.act_rd_en) reads++;
                @(posedge clk);
            end
            #1 bus.out_ready = 1'b1;
            total++;
            if (unstable !== 0) begin
                bad++;
                $display("FAIL bp_hold got %0d unstable cycles required 0", unstable);
            end
            total++;
            if (reads !== 0) begin
                bad++;
                $display("FAIL bp_reads got %0d reads during stall required 0", reads);
            end
        end
    endtask

    task automatic test_back_pressure;
        fill_seq(4);
        push_exp(0, 0, 5);
        push_exp(0, 1, 7);
        push_exp(1, 0, 13);
        push_exp(1, 1, 15);
        fork
            run_pass(1, 2, 2, 4, 4, 5, 0, "bp");
            stall_proc();
        join
    endtask

    task automatic try_bad(input int t, input int s, input int k, input int h, input int w,
                           input string name);
        int rc0, pulses, act, first;
        rc0 = rd_count;
        pulses = 0;
        act = 0;
        first = 0;
        do_start(t, s, k, h, w);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i == 0) first = int'(cfg_err);
            if (cfg_err) pulses++;
            if (busy || done) act++;
        end
        total++;
        if (first !== 1) begin
            bad++;
            $display("FAIL %s_err_timing got %0d required 1", name, first);
        end
        total++;
        if (pulses !== 1) begin
            bad++;
            $display("FAIL %s_err_pulses got %0d required 1", name, pulses);
        end
        total++;
        if (act !== 0) begin
            bad++;
            $display("FAIL %s_activity got %0d busy/done cycles required 0", name, act);
        end
        total++;
        if (rd_count !== rc0) begin
            bad++;
            $display("FAIL %s_reads got %0d required 0", name, rd_count - rc0);
        end
    endtask

    task automatic test_cfg_err;
        try_bad(2, 1, 3, 8, 8, "avg_k3");
        try_bad(2, 1, 0, 8, 8, "k0");
        try_bad(2, 1, 5, 8, 8, "k5");
        try_bad(3, 1, 1, 8, 8, "rsvd");
        try_bad(1, 0, 2, 8, 8, "s0");
        try_bad(1, 1, 3, 2, 8, "k_gt_h");
    endtask

    task automatic test_async_reset;
        int  hs0, done_seen;
        bit  hit;
        fill_seq(4);
        model_push(1, 2, 2, 4, 4);
        do_start(1, 2, 2, 4, 4);
        hs0 = hs_count;
        hit = 1'b0;
        for (int i = 0; i < 100 && !hit; i++) begin
            @(negedge clk);
            if (hs_count == hs0 + 1 && bus.act_rd_en) hit = 1'b1;
        end
        total++;
        if (!hit) begin
            bad++;
            $display("FAIL ar_second_fetch got none required act_rd_en");
        end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({busy, done, cfg_err, bus.out_valid, bus.act_rd_en} !== 5'b0) begin
            bad++;
            $display("FAIL ar_ctrl got %b required 00000",
                     {busy, done, cfg_err, bus.out_valid, bus.act_rd_en});
        end
        total++;
        if ({bus.act_rd_row, bus.act_rd_col, bus.out_data, bus.out_row, bus.out_col} !== '0) begin
            bad++;
            $display("FAIL ar_data got %h required 0",
                     {bus.act_rd_row, bus.act_rd_col, bus.out_data, bus.out_row, bus.out_col});
        end
        sb.delete();
        done_seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (done) done_seen++;
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) begin
            @(negedge clk);
            if (done || busy) done_seen++;
        end
        total++;
        if (done_seen !== 0) begin
            bad++;
            $display("FAIL ar_no_done got %0d done/busy cycles required 0", done_seen);
        end
        model_push(1, 2, 2, 4, 4);
        run_pass(1, 2, 2, 4, 4, 0, 4, "after_reset");
    endtask

    initial begin
        test_reset();
        test_none();
        test_max();
        test_avg();
        test_random();
        test_back_pressure();
        test_cfg_err();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
